// File: rtl/reg_acc_pkg.sv
// Shared types and constants for the register-access initiator.
package reg_acc_pkg;

    // Frame field widths: every frame byte is 8 bits, address/data fields fit inside one byte.
    localparam int FRAME_BYTE_W = 8;
    localparam int ADDR_W_MAX   = 8;
    localparam int DATA_W_MAX   = 8;

    // Default opcode and response byte values.
    localparam logic [FRAME_BYTE_W-1:0] OP_RD_DEF    = 8'h5A;
    localparam logic [FRAME_BYTE_W-1:0] OP_WR_DEF    = 8'hA5;
    localparam logic [FRAME_BYTE_W-1:0] ACK_BYTE_DEF = 8'hAC;
    localparam logic [FRAME_BYTE_W-1:0] ERR_BYTE_DEF = 8'hEE;

    // Fixed state encodings, kept stable so older logic-analyser decodes still match.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_WDATA  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        ADDR   = ST_ADDR,
        WDATA  = ST_WDATA,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } acc_state_t;

endpackage

// File: rtl/reg_acc_ctrl_to_cnt.sv
// Inter-byte timeout counter: expires after TO_CYC enabled cycles without a clear.
module acc_to_cnt #(
    parameter int TO_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt;

    // Count enabled idle cycles; any clear or leaving the waiting states restarts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr || !i_en) begin
            cnt <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A clear in the terminal cycle (a byte arriving just in time) suppresses expiry.
    assign o_expired = i_en && !i_clr && (cnt == CNT_LAST);

endmodule

// File: rtl/reg_acc_ctrl.sv
// Register-access initiator: decodes read/write byte frames, strobes the register
// bank for one cycle and returns one response byte per frame.
module reg_acc_ctrl
    import reg_acc_pkg::*;
#(
    parameter int                       AW       = 8,
    parameter int                       DW       = 8,
    parameter int                       TO_CYC   = 1024,
    parameter logic [FRAME_BYTE_W-1:0]  OP_RD    = OP_RD_DEF,
    parameter logic [FRAME_BYTE_W-1:0]  OP_WR    = OP_WR_DEF,
    parameter logic [FRAME_BYTE_W-1:0]  ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [FRAME_BYTE_W-1:0]  ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_vld,
    input  logic [FRAME_BYTE_W-1:0]  i_cmd_data,
    output logic                     o_cmd_rdy,
    output logic                     o_rsp_vld,
    output logic [FRAME_BYTE_W-1:0]  o_rsp_data,
    input  logic                     i_rsp_rdy,
    output logic                     o_ren,
    output logic                     o_wen,
    output logic [AW-1:0]            o_addr,
    output logic [DW-1:0]            o_wdata,
    input  logic [DW-1:0]            i_rdata,
    output logic                     o_err_to
);

    acc_state_t state;
    acc_state_t state_nx;
    logic       rd_flag;
    logic       rd_nx;
    logic       cmd_acc;
    logic       rsp_hs;
    logic       op_illegal;
    logic       to_en;
    logic       to_exp;

    // Read data narrower than a byte is returned with zero upper bits.
    function automatic logic [FRAME_BYTE_W-1:0] zext_rdata(input logic [DW-1:0] d);
        logic [FRAME_BYTE_W-1:0] r;
        r         = '0;
        r[DW-1:0] = d;
        return r;
    endfunction

    assign cmd_acc    = i_cmd_vld && o_cmd_rdy;
    assign rsp_hs     = o_rsp_vld && i_rsp_rdy;
    assign op_illegal = (i_cmd_data != OP_RD) && (i_cmd_data != OP_WR);
    assign to_en      = (state == ADDR) || (state == WDATA);

    // The counter is zero on entry to ADDR/WDATA because it is held clear everywhere else.
    acc_to_cnt #(
        .TO_CYC (TO_CYC)
    ) u_to_cnt (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (cmd_acc),
        .i_en      (to_en),
        .o_expired (to_exp)
    );

    // Next-state and read/write flag decode for the frame parser.
    always_comb begin
        state_nx = state;
        rd_nx    = rd_flag;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (i_cmd_data == OP_RD) begin
                        state_nx = ADDR;
                        rd_nx    = 1'b1;
                    end else if (i_cmd_data == OP_WR) begin
                        state_nx = ADDR;
                        rd_nx    = 1'b0;
                    end else begin
                        state_nx = RESP;
                    end
                end
            end
            ADDR: begin
                if (cmd_acc) begin
                    state_nx = rd_flag ? ACCESS : WDATA;
                end else if (to_exp) begin
                    state_nx = IDLE;
                end
            end
            WDATA: begin
                if (cmd_acc) begin
                    state_nx = ACCESS;
                end else if (to_exp) begin
                    state_nx = IDLE;
                end
            end
            ACCESS: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control registers: state plus every handshake/strobe output derived from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            rd_flag   <= 1'b0;
            o_cmd_rdy <= 1'b0;
            o_rsp_vld <= 1'b0;
            o_ren     <= 1'b0;
            o_wen     <= 1'b0;
            o_err_to  <= 1'b0;
        end else begin
            state     <= state_nx;
            rd_flag   <= rd_nx;
            o_cmd_rdy <= (state_nx == IDLE) || (state_nx == ADDR) || (state_nx == WDATA);
            o_rsp_vld <= (state_nx == RESP);
            o_ren     <= (state_nx == ACCESS) && rd_nx;
            o_wen     <= (state_nx == ACCESS) && !rd_nx;
            o_err_to  <= to_exp;
        end
    end

    // Address/data capture and response byte; all hold their value outside their load cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr     <= '0;
            o_wdata    <= '0;
            o_rsp_data <= '0;
        end else begin
            if ((state == ADDR) && cmd_acc) begin
                o_addr <= i_cmd_data[AW-1:0];
            end
            if ((state == WDATA) && cmd_acc) begin
                o_wdata <= i_cmd_data[DW-1:0];
            end
            if ((state == IDLE) && cmd_acc && op_illegal) begin
                o_rsp_data <= ERR_BYTE;
            end else if (state == ACCESS) begin
                o_rsp_data <= rd_flag ? zext_rdata(i_rdata) : ACK_BYTE;
            end
        end
    end

endmodule
